rf_wb_arbiter: RTL

- Owns the single write port (A3/WD3/WE3) of the 32x32 register file and shares it between two requesters.
- Requester P is the pipeline writeback: never back-pressured, highest priority.
- Requester S is the multi-cycle load/CSR unit: valid/ready handshake, buffered in a small FIFO, drained when the port is idle.
- Also exports a per-register pending mask for decode stalling, and a starvation stall request to the pipeline.

---
 rtl/rf_wb_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (P) always wins, the load/CSR
// unit (S) is queued and drained on idle cycles, with kill-on-overwrite and a starvation stall.
module rf_wb_arbiter #(
   parameter int XLEN       = 32,
   parameter int DEPTH      = 4,
   parameter int MAX_STARVE = 8
) (
   input  logic                   clk,
   input  logic                   areset,
   input  logic                   p_valid,
   input  logic [4:0]             p_rd,
   input  logic [XLEN-1:0]        p_data,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [4:0]             s_rd,
   input  logic [XLEN-1:0]        s_data,
   output logic [4:0]             A3,
   output logic [XLEN-1:0]        WD3,
   output logic                   WE3,
   output logic [31:0]            busy_mask,
   output logic                   stall_o,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(MAX_STARVE) + 1;
   localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_LAST = SW'(MAX_STARVE - 1);

   logic [4:0]      r_rd   [DEPTH];
   logic [XLEN-1:0] r_data [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [DEPTH-1:0] r_kill;
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;
   logic [SW-1:0]   r_starve;
   logic            r_stall;
   logic [4:0]      r_a3;
   logic [XLEN-1:0] r_wd3;
   logic            r_we3;

   logic             w_p_wr;
   logic             w_push;
   logic             w_pop;
   logic             w_head_kill;
   logic [DEPTH-1:0] w_kill_hit;
   logic [DEPTH-1:0] w_pop_oh;
   logic [DEPTH-1:0] w_push_oh;
   logic [DEPTH-1:0] w_vld_nxt;
   logic [DEPTH-1:0] w_kill_nxt;
   logic [31:0]      w_busy;

   assign w_p_wr      = p_valid & (p_rd != 5'd0);
   assign s_ready     = (r_count < FULL_CNT);
   assign w_push      = s_valid & s_ready & (s_rd != 5'd0);
   assign w_pop       = ~p_valid & (r_count != {CW{1'b0}});
   assign w_head_kill = r_kill[r_rptr];
   assign w_pop_oh    = w_pop  ? ({{(DEPTH-1){1'b0}}, 1'b1} << r_rptr) : {DEPTH{1'b0}};
   assign w_push_oh   = w_push ? ({{(DEPTH-1){1'b0}}, 1'b1} << r_wptr) : {DEPTH{1'b0}};
   // A same-cycle enqueue lands in the push slot with kill cleared, so it stays younger than P.
   assign w_vld_nxt   = (r_vld & ~w_pop_oh) | w_push_oh;
   assign w_kill_nxt  = (r_kill | w_kill_hit) & ~w_pop_oh & ~w_push_oh;

   // Kill matches and pending-register mask derived from stored entries.
   always_comb begin
      w_kill_hit = {DEPTH{1'b0}};
      w_busy     = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         w_kill_hit[i] = w_p_wr & r_vld[i] & (r_rd[i] == p_rd);
         w_busy        = w_busy | ({31'd0, r_vld[i] & ~r_kill[i]} << r_rd[i]);
      end
   end

   // S-side FIFO storage, pointers and occupancy.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         r_wptr  <= {AW{1'b0}};
         r_rptr  <= {AW{1'b0}};
         r_count <= {CW{1'b0}};
         r_vld   <= {DEPTH{1'b0}};
         r_kill  <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            r_rd[i]   <= 5'd0;
            r_data[i] <= {XLEN{1'b0}};
         end
      end else begin
         r_vld  <= w_vld_nxt;
         r_kill <= w_kill_nxt;
         if (w_push) begin
            r_rd[r_wptr]   <= s_rd;
            r_data[r_wptr] <= s_data;
            r_wptr         <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Registered write port; a killed head is consumed without asserting WE3.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         r_a3  <= 5'd0;
         r_wd3 <= {XLEN{1'b0}};
         r_we3 <= 1'b0;
      end else if (p_valid) begin
         r_a3  <= p_rd;
         r_wd3 <= p_data;
         r_we3 <= w_p_wr;
      end else if (w_pop) begin
         r_a3  <= r_rd[r_rptr];
         r_wd3 <= r_data[r_rptr];
         r_we3 <= ~w_head_kill;
      end else begin
         r_a3  <= 5'd0;
         r_wd3 <= {XLEN{1'b0}};
         r_we3 <= 1'b0;
      end
   end

   // Starvation counter: counts P grants while S waits, pulses stall_o on the last one.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         r_starve <= {SW{1'b0}};
         r_stall  <= 1'b0;
      end else if ((r_count == {CW{1'b0}}) || w_pop) begin
         r_starve <= {SW{1'b0}};
         r_stall  <= 1'b0;
      end else if (p_valid) begin
         if (r_starve == STARVE_LAST) begin
            r_starve <= {SW{1'b0}};
            r_stall  <= 1'b1;
         end else begin
            r_starve <= r_starve + 1'b1;
            r_stall  <= 1'b0;
         end
      end else begin
         r_starve <= r_starve;
         r_stall  <= 1'b0;
      end
   end

   assign A3         = r_a3;
   assign WD3        = r_wd3;
   assign WE3        = r_we3;
   assign busy_mask  = w_busy;
   assign stall_o    = r_stall;
   assign fifo_count = r_count;

endmodule
